// File: rtl/uart_pkg.sv
// Shared types and defaults for the UART receive path.
// The parity helper returns the parity bit a transmitter should send.
package uart_pkg;

    localparam int unsigned DATA_WIDTH    = 8;
    localparam int unsigned DIVIDER_WIDTH = 32;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT
    } uart_state_e;

    // Odd takes priority if both modes are requested; no parity yields 0.
    function automatic logic parity(input logic [DATA_WIDTH-1:0] data,
                                    input logic                  odd,
                                    input logic                  even);
        logic p;
        p = 1'b0;
        if (odd) begin
            p = ~(^data);
        end else if (even) begin
            p = ^data;
        end
        return p;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for the idle-high serial line.
// Both flops reset (and soft-clear) to 1 so reset never looks like a start bit.
module sync_2ff (
    input  logic clk_i,
    input  logic arstn_i,
    input  logic clr_i,
    input  logic d_i,
    output logic q_o
);

    logic [1:0] sync_q;
    logic [1:0] sync_d;

    always_comb begin
        sync_d = {sync_q[0], d_i};
        if (clr_i) begin
            sync_d = 2'b11;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= sync_d;
        end
    end

    assign q_o = sync_q[1];

endmodule

// File: rtl/axis_uart_rx.sv
// UART receiver with an AXI-Stream master output and a 1-deep holding register.
// Divider and parity mode are latched per frame at the start-bit falling edge.
module axis_uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = uart_pkg::DATA_WIDTH,
    parameter int unsigned DIVIDER_WIDTH = uart_pkg::DIVIDER_WIDTH
) (
    input  logic                     clk_i,
    input  logic                     arstn_i,
    input  logic                     rx_reset_i,
    input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
    input  logic                     parity_odd_i,
    input  logic                     parity_even_i,
    input  logic                     uart_rx_i,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tuser,
    output logic                     parity_err_o,
    output logic                     frame_err_o,
    output logic                     overrun_o
);

    localparam int unsigned BitCntW = $clog2(DATA_WIDTH + 1);
    localparam logic [DIVIDER_WIDTH-1:0] MinDiv = DIVIDER_WIDTH'(4);
    localparam logic [DIVIDER_WIDTH-1:0] One    = DIVIDER_WIDTH'(1);

    logic rx_s;

    sync_2ff u_sync (
        .clk_i  (clk_i),
        .arstn_i(arstn_i),
        .clr_i  (rx_reset_i),
        .d_i    (uart_rx_i),
        .q_o    (rx_s)
    );

    uart_state_e state_q, state_d;

    logic                     rx_prev_q, rx_prev_d;
    logic [DIVIDER_WIDTH-1:0] div_q, div_d;
    logic                     odd_q, odd_d;
    logic                     even_q, even_d;
    logic [DIVIDER_WIDTH-1:0] cnt_q, cnt_d;
    logic [BitCntW-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0]    shift_q, shift_d;
    logic                     perr_q, perr_d;
    logic [DATA_WIDTH-1:0]    tdata_q, tdata_d;
    logic                     tvalid_q, tvalid_d;
    logic                     tuser_q, tuser_d;
    logic                     perr_pulse_q, perr_pulse_d;
    logic                     ferr_q, ferr_d;
    logic                     ovr_q, ovr_d;

    logic [DIVIDER_WIDTH-1:0] half_div;
    logic                     tick;
    logic                     rx_fall;
    logic                     last_bit;
    logic                     byte_done;
    logic                     frame_bad;
    logic                     load;

    // FSM: state register
    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM: next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (rx_fall) state_d = START;
            START:   if (tick) state_d = rx_s ? IDLE : DATA;
            DATA:    if (tick && last_bit) state_d = (odd_q || even_q) ? PARITY : STOP;
            PARITY:  if (tick) state_d = STOP;
            STOP:    if (tick) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (rx_reset_i) begin
            state_d = IDLE;
        end
    end

    // FSM: decoded strobes; START waits half a bit, every later state a full bit
    always_comb begin
        half_div  = div_q >> 1;
        tick      = (state_q == START) ? (cnt_q == half_div - One) : (cnt_q == div_q - One);
        rx_fall   = rx_prev_q & ~rx_s;
        last_bit  = (bit_cnt_q == BitCntW'(DATA_WIDTH - 1));
        byte_done = (state_q == STOP) && tick && rx_s;
        frame_bad = (state_q == STOP) && tick && !rx_s;
        load      = byte_done && (!tvalid_q || m_axis_tready);
    end

    always_comb begin
        rx_prev_d    = rx_s;
        div_d        = div_q;
        odd_d        = odd_q;
        even_d       = even_q;
        cnt_d        = (state_q == IDLE || tick) ? '0 : cnt_q + One;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        perr_d       = perr_q;
        tdata_d      = tdata_q;
        tvalid_d     = tvalid_q;
        tuser_d      = tuser_q;
        perr_pulse_d = load && perr_q;
        ferr_d       = frame_bad;
        ovr_d        = byte_done && tvalid_q && !m_axis_tready;

        if (state_q == IDLE && rx_fall) begin
            div_d     = (clk_divider_i < MinDiv) ? MinDiv : clk_divider_i;
            odd_d     = parity_odd_i;
            even_d    = parity_even_i;
            bit_cnt_d = '0;
            perr_d    = 1'b0;
        end

        if (state_q == DATA && tick) begin
            shift_d   = {rx_s, shift_q[DATA_WIDTH-1:1]};
            bit_cnt_d = bit_cnt_q + BitCntW'(1);
        end

        if (state_q == PARITY && tick) begin
            perr_d = (rx_s != parity(shift_q, odd_q, even_q));
        end

        if (load) begin
            tvalid_d = 1'b1;
            tdata_d  = shift_q;
            tuser_d  = perr_q;
        end else if (tvalid_q && m_axis_tready) begin
            tvalid_d = 1'b0;
        end

        if (rx_reset_i) begin
            rx_prev_d    = 1'b1;
            div_d        = '0;
            odd_d        = 1'b0;
            even_d       = 1'b0;
            cnt_d        = '0;
            bit_cnt_d    = '0;
            shift_d      = '0;
            perr_d       = 1'b0;
            tdata_d      = '0;
            tvalid_d     = 1'b0;
            tuser_d      = 1'b0;
            perr_pulse_d = 1'b0;
            ferr_d       = 1'b0;
            ovr_d        = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge arstn_i) begin
        if (!arstn_i) begin
            rx_prev_q    <= 1'b1;
            div_q        <= '0;
            odd_q        <= 1'b0;
            even_q       <= 1'b0;
            cnt_q        <= '0;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            perr_q       <= 1'b0;
            tdata_q      <= '0;
            tvalid_q     <= 1'b0;
            tuser_q      <= 1'b0;
            perr_pulse_q <= 1'b0;
            ferr_q       <= 1'b0;
            ovr_q        <= 1'b0;
        end else begin
            rx_prev_q    <= rx_prev_d;
            div_q        <= div_d;
            odd_q        <= odd_d;
            even_q       <= even_d;
            cnt_q        <= cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            shift_q      <= shift_d;
            perr_q       <= perr_d;
            tdata_q      <= tdata_d;
            tvalid_q     <= tvalid_d;
            tuser_q      <= tuser_d;
            perr_pulse_q <= perr_pulse_d;
            ferr_q       <= ferr_d;
            ovr_q        <= ovr_d;
        end
    end

    assign m_axis_tdata  = tdata_q;
    assign m_axis_tvalid = tvalid_q;
    assign m_axis_tuser  = tuser_q;
    assign parity_err_o  = perr_pulse_q;
    assign frame_err_o   = ferr_q;
    assign overrun_o     = ovr_q;

endmodule

// File: doc/axis_uart_rx.md
AXIS_UART_RX -- requirements
Module: axis_uart_rx

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default uart_pkg::DATA_WIDTH (8), giving the payload bits per frame.
REQ-002 SHALL have parameter DIVIDER_WIDTH, default uart_pkg::DIVIDER_WIDTH (32), giving the width of the clock divider.
REQ-003 SHALL have port clk_i, input, 1, the single clock.
REQ-004 SHALL have port arstn_i, input, 1: reset is asynchronous and active-low.
REQ-005 SHALL have port rx_reset_i, input, 1, synchronous soft reset driven from control.rx_reset.
REQ-006 SHALL have port clk_divider_i, input, DIVIDER_WIDTH, giving clk_i cycles per bit.
REQ-007 SHALL have ports parity_odd_i and parity_even_i, input, 1 each; when both are 0 the frame has no parity bit.
REQ-008 SHALL have port uart_rx_i, input, 1, the asynchronous serial line, idle high.
REQ-009 SHALL have ports m_axis_tdata (output, DATA_WIDTH), m_axis_tvalid (output, 1) and m_axis_tready (input, 1) carrying received bytes.
REQ-010 SHALL have port m_axis_tuser, output, 1, set when the accompanying byte failed its parity check.
REQ-011 SHALL have ports parity_err_o, frame_err_o and overrun_o, output, 1 each, each a single-cycle pulse.

Function
REQ-012 SHALL pass uart_rx_i through a 2-flop synchronizer; all logic SHALL use only the synchronized value.
REQ-013 SHALL use an FSM of type uart_state_e with states IDLE, START, DATA, PARITY and STOP; WAIT SHALL be unused.
REQ-014 In IDLE, a falling edge on the synchronized line SHALL latch clk_divider_i and the parity mode, clear the baud counter, and go to START.
  - Divider or parity changes mid-frame SHALL NOT affect the current frame.
REQ-015 START SHALL sample after latched_div/2 cycles (integer division).
  - Sample high: false start; go to IDLE with no output.
  - Sample low: go to DATA.
REQ-016 DATA SHALL sample every latched_div cycles after the start mid-point.
  - Bits are shifted LSB first, DATA_WIDTH bits in total.
  - After the last bit, go to PARITY if parity is enabled, otherwise to STOP.
REQ-017 PARITY SHALL sample one bit, compare it to uart_pkg::parity(data, odd, even), and go to STOP.
  - A mismatch SHALL set the error captured for this byte.
REQ-018 STOP SHALL sample one bit, then return to IDLE.
  - Sample low: pulse frame_err_o and discard the byte (no tvalid).
  - Sample high: present the byte.
REQ-019 The byte SHALL be presented via a 1-deep output register.
  - m_axis_tvalid rises the cycle after the stop sample.
  - tdata and tuser SHALL hold stable until tvalid && tready.
REQ-020 If tvalid is still high when a new byte completes, overrun_o SHALL pulse and the new byte SHALL be dropped; the held byte is kept.
  - If tready is high in that same cycle, the held byte is consumed and the new byte is loaded with no overrun.
REQ-021 parity_err_o SHALL pulse in the same cycle that a byte with tuser=1 is loaded.
REQ-022 A divider value below 4 SHALL be treated as 4.
REQ-023 The baud counter SHALL be DIVIDER_WIDTH bits wide and never wrap within a bit period.

Reset
REQ-024 On arstn_i low, the FSM SHALL be IDLE and both synchronizer flops SHALL be 1.
REQ-025 On arstn_i low, m_axis_tvalid, m_axis_tdata, m_axis_tuser, parity_err_o, frame_err_o, overrun_o and all counters SHALL be 0.
REQ-026 rx_reset_i high SHALL give the same state as REQ-024/025 on the next edge, abandoning any frame in progress and any held byte.
REQ-027 Asserting reset mid-frame SHALL produce no output pulses; reception SHALL restart only on a fresh falling edge.

Structure
REQ-028 uart_state_e, the parity function, DATA_WIDTH and DIVIDER_WIDTH SHALL come from uart_pkg; no new package types are required.
REQ-029 The 2-flop synchronizer SHALL be one sub-module, sync_2ff; everything else stays inline.

Verification
REQ-030 Divider 16, no parity, byte 0xA5, tready=1 SHALL give tdata=0xA5 and tuser=0, with tvalid rising 1 cycle after the stop mid-point.
REQ-031 Odd parity, byte 0x03 with correct bit 1 SHALL give tuser=0; the same byte with bit 0 SHALL give tuser=1 and one parity_err_o pulse.
REQ-032 A 5-cycle low glitch at divider 16 SHALL give no tvalid and a return to IDLE.
REQ-033 Stop bit driven 0 SHALL give frame_err_o pulsed once and no tvalid.
REQ-034 tready=0 over two frames 0x11 then 0x22 SHALL give overrun_o pulsed once, with tdata holding 0x11 until accepted.
REQ-035 arstn_i pulsed during DATA, followed by a clean frame 0x5A, SHALL give exactly one output of 0x5A.
